// File: rtl/lz77_pkg.sv
// Shared types and geometry for the streaming LZ77 encoder.
package lz77_pkg;

  localparam int unsigned CHAR_W     = 8;
  localparam int unsigned SEARCH_LEN = 9;
  localparam int unsigned LOOK_LEN   = 8;
  localparam int unsigned OFF_W      = $clog2(SEARCH_LEN);
  localparam int unsigned LEN_W      = $clog2(LOOK_LEN);
  // Lookahead occupancy and shift counts span 0..LOOK_LEN inclusive.
  localparam int unsigned CNT_W      = $clog2(LOOK_LEN + 1);

  localparam logic [CHAR_W-1:0] END_CHAR = 8'h24;

  typedef enum logic [2:0] {
    ST_FILL,
    ST_MATCH,
    ST_EMIT,
    ST_SHIFT,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [OFF_W-1:0]  offset;
    logic [LEN_W-1:0]  match_len;
    logic [CHAR_W-1:0] char_nxt;
  } token_t;

endpackage

// File: rtl/lz77_match_unit.sv
// Parallel longest-match search of the lookahead against every search-window slot.
module lz77_match_unit
  import lz77_pkg::*;
(
  input  logic [SEARCH_LEN-1:0][CHAR_W-1:0] search,
  input  logic [SEARCH_LEN-1:0]             search_v,
  input  logic [LOOK_LEN-1:0][CHAR_W-1:0]   look,
  input  logic [CNT_W-1:0]                  look_cnt,
  output logic [OFF_W-1:0]                  offset,
  output logic [LEN_W-1:0]                  match_len
);

  int          lim;
  int unsigned len;
  int unsigned best_len;
  int unsigned best_k;
  logic        run;

  // Slot k is the start of a match whose i-th char sits at slot k-i; stopping at
  // i>k keeps the source inside the search window, lim keeps a char_nxt available.
  always_comb begin
    lim      = 32'(look_cnt) - 1;
    len      = 0;
    run      = 1'b0;
    best_len = 0;
    best_k   = 0;
    for (int k = 0; k < SEARCH_LEN; k++) begin
      len = 0;
      run = 1'b1;
      for (int i = 0; i < LOOK_LEN - 1; i++) begin
        if (run && (i <= k) && (i < lim) && search_v[OFF_W'(k - i)] &&
            (search[OFF_W'(k - i)] == look[LEN_W'(i)])) begin
          len++;
        end else begin
          run = 1'b0;
        end
      end
      if (len > best_len) begin
        best_len = len;
        best_k   = k;
      end
    end
    offset    = OFF_W'(best_k);
    match_len = LEN_W'(best_len);
  end

endmodule

// File: rtl/lz77_stream_encoder.sv
// Streaming LZ77 encoder: ready/valid char input, (offset, match_len, char_nxt) token output.
module lz77_stream_encoder
  import lz77_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [CHAR_W-1:0] chardata,
  input  logic              chardata_valid,
  output logic              chardata_ready,
  output logic              valid,
  input  logic              out_ready,
  output logic              encode,
  output logic [OFF_W-1:0]  offset,
  output logic [LEN_W-1:0]  match_len,
  output logic [CHAR_W-1:0] char_nxt,
  output logic              finish
);

  state_e                            state_q, state_d;
  logic [SEARCH_LEN-1:0][CHAR_W-1:0] search_q;
  logic [SEARCH_LEN-1:0]             search_v_q;
  logic [LOOK_LEN-1:0][CHAR_W-1:0]   look_q;
  logic [CNT_W-1:0]                  look_cnt_q;
  logic [CNT_W-1:0]                  shift_cnt_q;
  logic                              end_seen_q;
  logic                              run_q;
  logic                              tok_end_q;
  logic                              valid_q;
  logic                              finish_q;
  token_t                            tok_q;

  logic                              accept;
  logic                              shift_en;
  logic                              load_tok;
  logic [OFF_W-1:0]                  m_off;
  logic [LEN_W-1:0]                  m_len;

  lz77_match_unit u_match (
    .search    (search_q),
    .search_v  (search_v_q),
    .look      (look_q),
    .look_cnt  (look_cnt_q),
    .offset    (m_off),
    .match_len (m_len)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_FILL;
    else        state_q <= state_d;
  end

  // Next state plus handshake strobes; run_q holds ready low until the first edge after reset.
  always_comb begin
    state_d        = state_q;
    accept         = 1'b0;
    shift_en       = 1'b0;
    load_tok       = 1'b0;
    chardata_ready = 1'b0;
    unique case (state_q)
      ST_FILL: begin
        chardata_ready = run_q;
        accept         = run_q & chardata_valid;
        if (accept && ((chardata == END_CHAR) || (look_cnt_q == CNT_W'(LOOK_LEN - 1))))
          state_d = ST_MATCH;
      end
      ST_MATCH: begin
        load_tok = 1'b1;
        state_d  = ST_EMIT;
      end
      ST_EMIT: begin
        if (out_ready) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        chardata_ready = ~end_seen_q;
        accept         = ~end_seen_q & chardata_valid;
        shift_en       = end_seen_q | chardata_valid;
        if (shift_en && (shift_cnt_q == CNT_W'(1)))
          state_d = tok_end_q ? ST_DONE : ST_MATCH;
      end
      ST_DONE: ;
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      search_q    <= '0;
      search_v_q  <= '0;
      look_q      <= '0;
      look_cnt_q  <= '0;
      shift_cnt_q <= '0;
      end_seen_q  <= 1'b0;
      run_q       <= 1'b0;
      tok_end_q   <= 1'b0;
      valid_q     <= 1'b0;
      finish_q    <= 1'b0;
      tok_q       <= '0;
    end else begin
      run_q <= 1'b1;
      if (accept && (chardata == END_CHAR)) end_seen_q <= 1'b1;
      if ((state_q == ST_FILL) && accept) begin
        look_q[look_cnt_q[LEN_W-1:0]] <= chardata;
        look_cnt_q                    <= look_cnt_q + CNT_W'(1);
      end
      // Once the stream has ended the lookahead drains by inserting empty tail slots.
      if (shift_en) begin
        search_q    <= {search_q[SEARCH_LEN-2:0], look_q[0]};
        search_v_q  <= {search_v_q[SEARCH_LEN-2:0], 1'b1};
        look_q      <= {(accept ? chardata : CHAR_W'(0)), look_q[LOOK_LEN-1:1]};
        shift_cnt_q <= shift_cnt_q - CNT_W'(1);
        if (!accept) look_cnt_q <= look_cnt_q - CNT_W'(1);
      end
      if (load_tok) begin
        tok_q.offset    <= m_off;
        tok_q.match_len <= m_len;
        tok_q.char_nxt  <= look_q[m_len];
        tok_end_q       <= (look_q[m_len] == END_CHAR);
        shift_cnt_q     <= CNT_W'(m_len) + CNT_W'(1);
        valid_q         <= 1'b1;
      end
      if ((state_q == ST_EMIT) && out_ready) valid_q <= 1'b0;
      if (state_d == ST_DONE) finish_q <= 1'b1;
    end
  end

  assign valid     = valid_q;
  assign finish    = finish_q;
  assign encode    = 1'b1;
  assign offset    = tok_q.offset;
  assign match_len = tok_q.match_len;
  assign char_nxt  = tok_q.char_nxt;

endmodule

// File: tb/tb_lz77_stream_encoder.sv
// Scoreboard bench for lz77_stream_encoder: directed strings, backpressure, input gaps, mid-run reset.
module tb_lz77_stream_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] chardata;
  logic       chardata_valid;
  logic       chardata_ready;
  logic       valid;
  logic       out_ready;
  logic       encode;
  logic [3:0] offset;
  logic [2:0] match_len;
  logic [7:0] char_nxt;
  logic       finish;

  int n_chk  = 0;
  int n_fail = 0;
  int tok_count = 0;
  int bp_tok = -1;
  bit bp_arm = 1'b0;
  bit stall_prev = 1'b0;
  logic [14:0] held;
  logic [14:0] exp_q[$];

  always #5 clk = ~clk;

  lz77_stream_encoder dut (
    .clk            (clk),
    .reset          (reset),
    .chardata       (chardata),
    .chardata_valid (chardata_valid),
    .chardata_ready (chardata_ready),
    .valid          (valid),
    .out_ready      (out_ready),
    .encode         (encode),
    .offset         (offset),
    .match_len      (match_len),
    .char_nxt       (char_nxt),
    .finish         (finish)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push(input int o, input int l, input byte c);
    exp_q.push_back({4'(o), 3'(l), 8'(c)});
  endtask

  // Monitor: pops on every handshake and checks hold-stability while stalled.
  always @(negedge clk) begin
    logic [14:0] got;
    logic [14:0] exp;
    got = {offset, match_len, char_nxt};
    if (reset && valid) begin
      if (stall_prev) begin
        n_chk++;
        if (got !== held) begin
          n_fail++;
          $display("FAIL stall_stable: got %h expected %h", got, held);
        end
      end
      if (out_ready) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL extra_token: got %h expected none", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            n_fail++;
            $display("FAIL token%0d: got off=%0d len=%0d ch=%h expected off=%0d len=%0d ch=%h",
                     tok_count, got[14:11], got[10:8], got[7:0], exp[14:11], exp[10:8], exp[7:0]);
          end
        end
        n_chk++;
        if (finish !== 1'b0) begin
          n_fail++;
          $display("FAIL finish_early: got %b expected 0", finish);
        end
        tok_count++;
        stall_prev = 1'b0;
      end else begin
        stall_prev = 1'b1;
        held = got;
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Backpressure: hold out_ready low for 5 cycles when the armed token appears.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (bp_arm && valid && (tok_count == bp_tok)) begin
        bp_arm = 1'b0;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    end
  end

  task automatic send_str(input string s, input bit gaps);
    int i = 0;
    int guard = 0;
    while (i < s.len() && guard < 2000) begin
      @(posedge clk); #1;
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        chardata_valid = 1'b0;
      end else begin
        chardata = s[i];
        chardata_valid = 1'b1;
        @(negedge clk);
        if (chardata_ready) i++;
      end
      guard++;
    end
    check("send_timeout", 32'(i), 32'(s.len()));
    @(posedge clk); #1 chardata_valid = 1'b0;
  endtask

  task automatic wait_finish();
    int n = 0;
    while (!finish && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("finish", 32'(finish), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic run_case(input string s, input bit gaps);
    send_str(s, gaps);
    wait_finish();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("done_valid", 32'(valid), 32'd0);
    check("done_ready", 32'(chardata_ready), 32'd0);
    exp_q.delete();
    do_reset();
  endtask

  task automatic push_abc();
    push(0, 0, "a"); push(0, 0, "b"); push(0, 0, "c"); push(2, 3, "a"); push(2, 2, "$");
  endtask

  initial begin
    int n;
    int base;
    reset = 1'b0;
    chardata = 8'h00;
    chardata_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("rst_ready", 32'(chardata_ready), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_finish", 32'(finish), 32'd0);
    check("rst_offset", 32'(offset), 32'd0);
    check("rst_len", 32'(match_len), 32'd0);
    check("rst_char", 32'(char_nxt), 32'd0);
    check("encode", 32'(encode), 32'd1);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", 32'(chardata_ready), 32'd1);

    push(0, 0, "a"); push(0, 1, "a"); push(0, 1, "$");
    run_case("aaaa$", 1'b0);

    push_abc();
    run_case("abcabcabc$", 1'b0);

    push(0, 0, "a"); push(0, 0, "b"); push(1, 2, "$");
    run_case("abab$", 1'b0);

    push(0, 0, "$");
    run_case("$", 1'b0);

    push_abc();
    bp_tok = tok_count + 1;
    bp_arm = 1'b1;
    run_case("abcabcabc$", 1'b0);
    check("bp_consumed", 32'(bp_arm), 32'd0);

    push_abc();
    run_case("abcabcabc$", 1'b1);

    push_abc();
    base = tok_count;
    send_str("abcabcabc$", 1'b0);
    n = 0;
    while (tok_count < base + 4 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_shift", 32'(tok_count - base), 32'd4);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_offset", 32'(offset), 32'd0);
    check("mid_rst_len", 32'(match_len), 32'd0);
    check("mid_rst_char", 32'(char_nxt), 32'd0);
    check("mid_rst_finish", 32'(finish), 32'd0);
    check("mid_rst_ready", 32'(chardata_ready), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    push(0, 0, "a"); push(0, 0, "b"); push(1, 2, "$");
    run_case("abab$", 1'b0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
